clmul_reduce: RTL and testbench
===============================

// Module: clmul_reduce
// PURPOSE
//  Downstream stage of the carry-less multiplier: consumes a 64-bit GF(2) product
//  and reduces it modulo a fixed degree-32 polynomial P(x) = x^32 + POLY.
//  Multi-cycle, BITS_PER_CYCLE quotient bits per cycle, valid/ready handshake on both sides.
//  Result is a 32-bit remainder for CRC / GF(2^32) arithmetic in the execute stage.
// PARAMETERS
//  POLY            32'h04C11DB7  low 32 coefficients of P(x); x^32 term implicit
//  BITS_PER_CYCLE  8             reduction bits per cycle; one of 1,2,4,8,16,32
// PORTS
//  clk        in   1   clock
//  resetn     in   1   synchronous, active-low reset
//  in_valid   in   1   operand valid
//  in_ready   out  1   block can accept operand this cycle
//  in_data    in   64  carry-less product to reduce
//  in_reflect in   1   bit-reflected mode; present only with CLMUL_REDUCE_REFLECT_EN
//  out_valid  out  1   remainder valid, held until accepted
//  out_ready  in   1   consumer accepts remainder
//  out_data   out  32  D mod P, registered
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0, out_data=0, working reg W=0, counter=0; in_ready=1.
//  - FSM: IDLE -(in_valid)-> RUN -(counter==0 after last step)-> DONE -(out_ready)-> IDLE/RUN.
//  - Accept: in_valid && in_ready loads W<=in_data, counter<=32/BITS_PER_CYCLE, goes to RUN.
//  - Step, per bit, MSB first: W = (W[63] ? W ^ {1'b1,POLY,31'b0} : W) << 1.
//    Each RUN cycle applies BITS_PER_CYCLE steps and decrements the counter.
//  - When the counter reaches 0: out_data<=W[63:32], out_valid<=1, state DONE.
//  - Latency: accept at cycle 0 -> out_valid high at cycle 32/BITS_PER_CYCLE (4 at default).
//  - in_ready = (state==IDLE) || (state==DONE && out_ready). Never high in RUN.
//  - DONE with out_ready=1 and in_valid=1 in the same cycle: result retires and the new
//    operand is loaded in that cycle (state->RUN). Back-to-back throughput is 1 per 32/BPC+1 cycles.
//  - DONE with out_ready=0: out_data/out_valid held stable; in_valid ignored.
//  - in_data with D[63:32]==0: remainder == D[31:0].
//  - resetn low in any state, including mid-RUN: operation abandoned, reset values the next cycle.
//  - in_data is sampled only on accept; later changes have no effect.
// CONFIGURATION
//  CLMUL_REDUCE_REFLECT_EN defined: the in_reflect port exists. in_reflect is captured on accept.
//    If set, the operand is bit-reversed (64-bit) before loading W and the 32-bit remainder
//    is bit-reversed before out_data. Latency is unchanged.
//  Not defined: no in_reflect port and no reversal logic; MSB-first only.
// STRUCTURE
//  clmul_pkg: FSM enum typedef (IDLE, RUN, DONE), constant CLMUL_PROD_W=64, CLMUL_RED_W=32,
//    and a function bitrev32/bitrev64 used under the macro.
//  Sub-module clmul_reduce_step: combinational, applies BITS_PER_CYCLE steps to W (POLY, BPC params).
//  Top: FSM, counter ($clog2(32/BPC+1) bits), W register, output register.
// TESTING
//  1. in_data=64'h0000_0001_0000_0000 -> out_data=32'h04C11DB7, out_valid 4 cycles after accept.
//  2. in_data=64'h0000_0000_DEAD_BEEF -> out_data=32'hDEADBEEF (no reduction).
//  3. Hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0; then out_ready=1 with
//     in_valid=1 -> same-cycle retire+accept, next result 4 cycles later.
//  4. Assert resetn=0 during RUN cycle 2 -> next cycle out_valid=0, in_ready=1, out_data=0.
//  5. Random 64-bit operands, all BITS_PER_CYCLE values -> match software polynomial modulo model.
//  6. (CLMUL_REDUCE_REFLECT_EN) in_reflect=1, in_data=64'h0000_0000_8000_0000 -> out_data=32'hEDB88320.

Source files
------------

// File: rtl/clmul_pkg.sv
// Shared types, widths and bit-reversal helpers for the carry-less product reduction stage.
// The reversal functions are only referenced when CLMUL_REDUCE_REFLECT_EN is defined.
package clmul_pkg;

    localparam int unsigned CLMUL_PROD_W = 64;
    localparam int unsigned CLMUL_RED_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } clmul_state_e;

    function automatic logic [CLMUL_RED_W-1:0] bitrev32(input logic [CLMUL_RED_W-1:0] x);
        logic [CLMUL_RED_W-1:0] r;
        for (int unsigned i = 0; i < CLMUL_RED_W; i++) begin
            r[i] = x[CLMUL_RED_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [CLMUL_PROD_W-1:0] bitrev64(input logic [CLMUL_PROD_W-1:0] x);
        logic [CLMUL_PROD_W-1:0] r;
        for (int unsigned i = 0; i < CLMUL_PROD_W; i++) begin
            r[i] = x[CLMUL_PROD_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/clmul_reduce_step.sv
// Combinational reduction slice: applies BITS_PER_CYCLE MSB-first long-division
// steps of the working register against P(x) = x^32 + POLY.
module clmul_reduce_step
    import clmul_pkg::*;
#(
    parameter logic [31:0] POLY           = 32'h04C11DB7,
    parameter int unsigned BITS_PER_CYCLE = 8
) (
    input  logic [CLMUL_PROD_W-1:0] i_w,
    output logic [CLMUL_PROD_W-1:0] o_w_c
);

    // Divisor aligned so that its x^32 term cancels bit 63 of the working register.
    localparam logic [CLMUL_PROD_W-1:0] REDUCE_MASK = {1'b1, POLY, 31'b0};

    logic [CLMUL_PROD_W-1:0] w_acc;

    always_comb begin
        w_acc = i_w;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            w_acc = (w_acc[CLMUL_PROD_W-1] ? (w_acc ^ REDUCE_MASK) : w_acc) << 1;
        end
        o_w_c = w_acc;
    end

endmodule

// File: rtl/clmul_reduce.sv
// Multi-cycle reducer of a 64-bit GF(2) product modulo x^32 + POLY with valid/ready on both sides.
// Optional bit-reflected mode is built when CLMUL_REDUCE_REFLECT_EN is defined.
module clmul_reduce
    import clmul_pkg::*;
#(
    parameter logic [31:0] POLY           = 32'h04C11DB7,
    parameter int unsigned BITS_PER_CYCLE = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CLMUL_PROD_W-1:0] in_data,
`ifdef CLMUL_REDUCE_REFLECT_EN
    input  logic                    in_reflect,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CLMUL_RED_W-1:0]  out_data
);

    localparam int unsigned STEPS = CLMUL_RED_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    clmul_state_e            r_state;
    logic [CLMUL_PROD_W-1:0] r_w;
    logic [CNT_W-1:0]        r_cnt;
    logic [CLMUL_RED_W-1:0]  r_out_data;
    logic                    r_out_valid;

    logic                    w_accept;
    logic [CLMUL_PROD_W-1:0] w_load;
    logic [CLMUL_PROD_W-1:0] w_step;
    logic [CLMUL_RED_W-1:0]  w_rem;

    clmul_reduce_step #(
        .POLY           (POLY),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_w   (r_w),
        .o_w_c (w_step)
    );

    // A finished result retiring frees the slot for a new operand in the same cycle.
    assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef CLMUL_REDUCE_REFLECT_EN
    logic r_reflect;
    assign w_load = in_reflect ? bitrev64(in_data) : in_data;
    assign w_rem  = r_reflect ? bitrev32(w_step[CLMUL_PROD_W-1:CLMUL_RED_W])
                              : w_step[CLMUL_PROD_W-1:CLMUL_RED_W];
`else
    assign w_load = in_data;
    assign w_rem  = w_step[CLMUL_PROD_W-1:CLMUL_RED_W];
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_w         <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
`ifdef CLMUL_REDUCE_REFLECT_EN
            r_reflect   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state     <= RUN;
            r_w         <= w_load;
            r_cnt       <= CNT_W'(STEPS);
            r_out_valid <= 1'b0;
`ifdef CLMUL_REDUCE_REFLECT_EN
            r_reflect   <= in_reflect;
`endif
        end else begin
            case (r_state)
                RUN: begin
                    r_w   <= w_step;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last slice: publish the remainder directly from the step output.
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_data  <= w_rem;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_clmul_reduce.sv
// Directed and model-checked bench for clmul_reduce: main instance at BITS_PER_CYCLE=8
// plus one instance for each other supported slice width.
module tb_clmul_reduce;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam int          NX   = 5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_reflect;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    logic [NX-1:0] x_in_valid;
    logic [NX-1:0] x_in_ready;
    logic [NX-1:0] x_out_valid;
    logic [NX-1:0] x_out_ready;
    logic [63:0]   x_in_data;
    logic [31:0]   x_out_data [NX];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clmul_reduce #(.POLY(POLY), .BITS_PER_CYCLE(8)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
`ifdef CLMUL_REDUCE_REFLECT_EN
        .in_reflect (in_reflect),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    // Slice widths 1,2,4,16,32 for k = 0..4.
    for (genvar k = 0; k < NX; k++) begin : g_bpc
        localparam int unsigned BPC_K = 1 << ((k < 3) ? k : k + 1);
        clmul_reduce #(.POLY(POLY), .BITS_PER_CYCLE(BPC_K)) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .in_valid   (x_in_valid[k]),
            .in_ready   (x_in_ready[k]),
            .in_data    (x_in_data),
`ifdef CLMUL_REDUCE_REFLECT_EN
            .in_reflect (1'b0),
`endif
            .out_valid  (x_out_valid[k]),
            .out_ready  (x_out_ready[k]),
            .out_data   (x_out_data[k])
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Plain polynomial long division, highest degree first.
    function automatic logic [31:0] mod_model(input logic [63:0] d);
        logic [63:0] r;
        logic [63:0] p;
        r = d;
        p = {31'd0, 1'b1, POLY};
        for (int i = 63; i >= 32; i--) begin
            if (r[i]) r = r ^ (p << (i - 32));
        end
        return r[31:0];
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63 - i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31 - i];
        return r;
    endfunction

    // Called at the negedge just after the accept edge; counts edges until out_valid.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] d, input logic refl,
                          input logic [31:0] exp);
        int lat;
        @(negedge clk);
        in_data    = d;
        in_valid   = 1'b1;
        in_reflect = refl;
        #1;
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid   = 1'b0;
        in_reflect = 1'b0;
        in_data    = 64'hA5A5_5A5A_F0F0_0F0F;
        wait_out(lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'd4);
        check_eq({tag, "_data"}, 64'(out_data), 64'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_retired"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_x(input int k, input logic [63:0] d);
        int lat;
        int bpc;
        bpc = 1 << ((k < 3) ? k : k + 1);
        @(negedge clk);
        x_in_data     = d;
        x_in_valid[k] = 1'b1;
        @(negedge clk);
        x_in_valid[k] = 1'b0;
        x_in_data     = ~d;
        lat = 0;
        while (!x_out_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq($sformatf("bpc%0d_latency", bpc), 64'(lat), 64'(32 / bpc));
        check_eq($sformatf("bpc%0d_data", bpc), 64'(x_out_data[k]), 64'(mod_model(d)));
        x_out_ready[k] = 1'b1;
        @(negedge clk);
        x_out_ready[k] = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        logic [31:0] held;
        int          lat;

        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_reflect  = 1'b0;
        out_ready   = 1'b0;
        x_in_valid  = '0;
        x_out_ready = '0;
        x_in_data   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        resetn = 1'b1;

        // x^32 reduces to POLY; an operand below x^32 is its own remainder.
        run_op("x32", 64'h0000_0001_0000_0000, 1'b0, 32'h04C11DB7);
        run_op("noreduce", 64'h0000_0000_DEAD_BEEF, 1'b0, 32'hDEADBEEF);
        run_op("x63", 64'h8000_0000_0000_0000, 1'b0, mod_model(64'h8000_0000_0000_0000));

        // Back-pressure in DONE, then same-cycle retire + accept.
        @(negedge clk);
        in_data  = 64'h1234_5678_9ABC_DEF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        held = out_data;
        check_eq("bp_first_data", 64'(held), 64'(mod_model(64'h1234_5678_9ABC_DEF0)));
        in_valid = 1'b1;
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            check_eq("bp_hold_data", 64'(out_data), 64'(held));
            check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        in_data   = 64'hCAFE_F00D_0BAD_BEEF;
        #1;
        check_eq("b2b_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("b2b_out_valid_low", 64'(out_valid), 64'd0);
        check_eq("b2b_run_not_ready", 64'(in_ready), 64'd0);
        wait_out(lat);
        check_eq("b2b_latency", 64'(lat), 64'd4);
        check_eq("b2b_data", 64'(out_data), 64'(mod_model(64'hCAFE_F00D_0BAD_BEEF)));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN abandons the operation.
        @(negedge clk);
        in_data  = 64'hFEDC_BA98_7654_3210;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_out_data", 64'(out_data), 64'd0);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("midrst_stays_idle", 64'(out_valid), 64'd0);

        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom};
            run_op($sformatf("rand%0d", i), d, 1'b0, mod_model(d));
        end

        for (int k = 0; k < NX; k++) begin
            run_x(k, 64'h0000_0001_0000_0000);
            for (int i = 0; i < 3; i++) begin
                d = {$urandom, $urandom};
                run_x(k, d);
            end
        end

`ifdef CLMUL_REDUCE_REFLECT_EN
        run_op("refl_bit31", 64'h0000_0000_8000_0000, 1'b1, 32'hEDB88320);
        d = {$urandom, $urandom};
        run_op("refl_rand", d, 1'b1, rev32(mod_model(rev64(d))));
        run_op("refl_off", 64'h0000_0001_0000_0000, 1'b0, 32'h04C11DB7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
